// File: rtl/step_ctrl_pkg.sv
// Shared encodings for the command-driven step controller.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/step_cmd_ctrl_if.sv
// Move-command valid/ready bus: direction plus unsigned step count.
interface step_cmd_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;

    modport master (output cmd_valid, output cmd_dir, output cmd_steps, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_dir, input  cmd_steps, output cmd_ready);
endinterface

// File: rtl/step_tick_gen.sv
// DIV-cycle divider: counts 0..DIV-1 while enabled, tick high at DIV-1.
// Synchronous clear restarts the phase so the first step of a move lands
// exactly DIV cycles after the command handshake.
module step_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    // Divider count: clear wins, otherwise wrap at DIV-1 while enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/step_cmd_ctrl.sv
// Command-driven step controller for the 4-phase step sequencer.
// Accepts (dir, steps) moves, emits one-cycle step strobes every DIV clocks,
// tracks absolute position and pulses done when a move finishes.
// Optional feature: define STEP_CTRL_ABORT_EN to add the abort input.
module step_cmd_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int POS_W = 16,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    step_cmd_ctrl_if.slave   cmd,
`ifdef STEP_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos
);
    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             tick;
    logic             accept;
    logic             abort_now;

    assign accept = cmd.cmd_valid && (state == ST_IDLE);

`ifdef STEP_CTRL_ABORT_EN
    // abort only has an effect while a move is running
    assign abort_now = abort && (state == ST_RUN);
`else
    assign abort_now = 1'b0;
`endif

    step_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (state == ST_RUN),
        .tick  (tick)
    );

    // Output decode from the registered state.
    always_comb begin
        cmd.cmd_ready = (state == ST_IDLE);
        busy          = (state == ST_RUN);
        done          = (state == ST_DONE);
        step          = (state == ST_RUN) && tick;
    end

    // Move sequencing FSM with remaining-step counter and position accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            dir       <= DIR_FWD;
            remaining <= '0;
            pos       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        dir       <= cmd.cmd_dir;
                        remaining <= cmd.cmd_steps;
                        state     <= (cmd.cmd_steps == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        remaining <= remaining - CNT_W'(1);
                        pos       <= (dir == DIR_REV) ? pos - POS_W'(1) : pos + POS_W'(1);
                        if (remaining == CNT_W'(1))
                            state <= ST_DONE;
                    end
                    // a step coinciding with abort is still issued and counted
                    if (abort_now)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/step_cmd_ctrl.md
# step_cmd_ctrl

Command-driven step controller that sequences the 4-phase step sequencer used in the Parcial2 designs. It accepts move commands (direction + step count) over a valid/ready handshake. It emits one-cycle `step` strobes at a fixed clock-divided rate, together with a `dir` level that drives the sequencer's direction input (0 = forward S0→S1→S2→S3, 1 = reverse). It also tracks absolute position and signals completion.

## Interface
Parameters:
- `CNT_W`, default 8: width of step-count field.
- `POS_W`, default 16: width of position counter.
- `DIV`, default 4: clock cycles per step; legal range 2..255.

Ports:
- `clk`  in  1: clock, all logic on rising edge.
- `reset`  in  1: asynchronous, active-high.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: controller can accept a command.
- `cmd_dir`  in  1: 0 forward, 1 reverse.
- `cmd_steps`  in  CNT_W: number of steps, unsigned.
- `step`  out  1: one-cycle strobe, advance the sequencer one state.
- `dir`  out  1: direction for the sequencer.
- `busy`  out  1: move in progress.
- `done`  out  1: one-cycle completion pulse.
- `pos`  out  POS_W: absolute position, two's complement.
- `abort`  in  1: present only with `STEP_CTRL_ABORT_EN`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready`: latch `cmd_dir` into `dir`, latch `cmd_steps` into `remaining`, clear the divider.
  - If `cmd_steps` == 0, go to DONE; otherwise go to RUN.
- **RUN:**
  - Divider counts 0..DIV-1; `step` = 1 in the cycle the divider equals DIV-1.
  - On each step: `remaining` decrements and `pos` += (dir ? -1 : +1), modulo 2^POS_W with no saturation.
  - After the step that brings `remaining` to 0, go to DONE.
- **DONE:** `done` = 1 for exactly one cycle, then go to IDLE.
- **Output decode:** `cmd_ready` = (state==IDLE); `busy` = (state==RUN).
- **`dir`:** holds its value until the next accepted command.
- **`cmd_valid` outside IDLE:** ignored; the command stays pending at the source.
- **Reset values:** state IDLE, `step` 0, `dir` 0, `busy` 0, `done` 0, `pos` 0, `remaining` 0, divider 0. `cmd_ready` is 1 during and after reset.
- **Reset mid-move:** the move is discarded immediately, with no `done` pulse and `pos` returning to 0.

## Timing
- Cycle 0 is the cycle in which the handshake occurs.
- **Steps:** for N ≥ 1, `busy` = 1 in cycles 1..N·DIV, and `step` = 1 in cycles j·DIV for j = 1..N.
- **`pos`:** reflects step j from cycle j·DIV+1.
- **Completion:** `done` = 1 in cycle N·DIV+1; `cmd_ready` = 1 again from cycle N·DIV+2.
- **Zero-step command:** `done` in cycle 1, `cmd_ready` in cycle 2, no `step`, `pos` unchanged.
- **Back-to-back commands:** minimum spacing between handshakes is N·DIV+2 cycles.

## Configuration
- **`STEP_CTRL_ABORT_EN` defined:**
  - `abort` port exists and is sampled in RUN only; it is ignored in IDLE and DONE.
  - If `abort` = 1 in a RUN cycle, the next state is DONE and the remaining steps are discarded.
  - If that cycle is also a step cycle, the step is issued and counted in `pos`.
  - `done` pulses in the following cycle.
- **Undefined:** no `abort` port; every move runs to completion.

## Structure
- **Package `step_ctrl_pkg`:** state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and `DIR_FWD`=1'b0, `DIR_REV`=1'b1.
- **Sub-module `step_tick_gen`:** DIV-cycle divider with synchronous clear and a `tick` output. It is instantiated once and cleared on command accept.
- **Top level:** FSM, `remaining` counter and `pos` accumulator.

## Test plan
Defaults throughout: DIV=4, POS_W=16.
- **Forward move:** forward, 3 steps → `step` in cycles 4, 8, 12; `pos` 0→1→2→3; `done` in cycle 13; `cmd_ready` in cycle 14.
- **Reverse wrap:** from `pos`=0, reverse, 1 step → `step` in cycle 4; `pos` = 16'hFFFF from cycle 5; `dir` = 1 held afterwards.
- **Zero steps:** `cmd_steps`=0 → `done` in cycle 1; no `step`; `pos` unchanged; `busy` never 1.
- **Held `cmd_valid`:** `cmd_valid` held high with a second command (forward, 2) during a 3-step move → second handshake in cycle 14; its steps in cycles 18 and 22; final `pos` = 5.
- **Reset mid-move:** `reset` pulsed in cycle 6 of a 5-step move → all outputs return to reset values asynchronously; no `done`; `pos` = 0; `cmd_ready` = 1.
- **Abort (with `STEP_CTRL_ABORT_EN`):** `abort` in cycle 8 of a 5-step forward move → `step` in cycles 4 and 8 only; `pos` = 2; `done` in cycle 9.
